// File: rtl/demux1to2_buf_pkg.sv
// Shared constants for the buffered 1-to-2 demultiplexer: widths, buffer depth,
// occupancy encodings and destination select codes.
package demux1to2_buf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BUF_DEPTH  = 2;
    localparam int COUNT_W    = 8;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    function automatic logic [COUNT_W-1:0] count_next(input logic [COUNT_W-1:0] c);
        return c + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/demux1to2_buf_fifo2.sv
// Two-entry FIFO with an explicit EMPTY/ONE/FULL occupancy state machine;
// one instance backs each demultiplexer output.
module demux_fifo2
    import demux1to2_buf_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    occ_e             state;
    occ_e             state_next;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Guarding here keeps the occupancy state legal even if a caller misbehaves.
    assign do_push = push && (state != FULL);
    assign do_pop  = pop  && (state != EMPTY);

    assign head  = mem[rd_ptr];
    assign full  = (state == FULL);
    assign empty = (state == EMPTY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Push and pop together in ONE leaves occupancy unchanged; the pointers
    // advance so the newly written word becomes head.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (do_push) state_next = ONE;
            end
            ONE: begin
                if (do_push && !do_pop)      state_next = FULL;
                else if (do_pop && !do_push) state_next = EMPTY;
            end
            FULL: begin
                if (do_pop) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

endmodule

// File: rtl/demux1to2_buf.sv
// Buffered 1-to-2 demultiplexer: routes each accepted word to one of two
// independent 2-entry FIFOs and counts words accepted per destination.
module demux1to2_buf
    import demux1to2_buf_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out0_data,
    output logic               out0_valid,
    input  logic               out0_ready,
    output logic [WIDTH-1:0]   out1_data,
    output logic               out1_valid,
    input  logic               out1_ready,
    output logic [COUNT_W-1:0] out0_count,
    output logic [COUNT_W-1:0] out1_count
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Readiness looks only at registered full flags, so a same-cycle pop on a
    // full buffer never opens a slot for the incoming word.
    assign in_ready = (in_sel == SEL_OUT1) ? !full1 : !full0;

    assign push0 = in_valid && (in_sel == SEL_OUT0) && !full0;
    assign push1 = in_valid && (in_sel == SEL_OUT1) && !full1;

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    demux_fifo2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .wdata (in_data),
        .pop   (pop0),
        .head  (out0_data),
        .full  (full0),
        .empty (empty0)
    );

    demux_fifo2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .wdata (in_data),
        .pop   (pop1),
        .head  (out1_data),
        .full  (full1),
        .empty (empty1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out0_count <= '0;
            out1_count <= '0;
        end else begin
            if (push0) out0_count <= count_next(out0_count);
            if (push1) out1_count <= count_next(out1_count);
        end
    end

endmodule
